// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Captures one trace record per active retirement cycle into a small FIFO
//   and keeps retired-instruction / active-cycle counters.
//
//   Optional feature macro: TRACE_WATCHDOG_EN
//     When defined, a watchdog sets 'timeout' once cycle_count reaches 100000
//     without a halt and stops further capture (halted stays 0).
//
//   Ports
//     clk, rst             : clock, asynchronous active-high reset
//     en                   : capture enable
//     pc, inst             : retiring PC / instruction
//     reg_write, mem_read,
//     mem_write, hlt       : retirement qualifiers
//     write_reg            : destination register
//     write_data, mem_addr,
//     mem_data             : register write value, memory address, store data
//     rd_valid/rd_ready    : head-record handshake
//     rd_data              : {kind[2:0], pc[15:0], reg[3:0], a[15:0], b[15:0]}
//     inst_count,
//     cycle_count          : saturating counters
//     overflow, halted     : sticky status
//     timeout              : watchdog flag (0 unless TRACE_WATCHDOG_EN)
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        hlt,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [54:0] rd_data,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic        overflow,
  output logic        halted,
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] K_REG   = 3'd0;
  localparam logic [2:0] K_LD    = 3'd1;
  localparam logic [2:0] K_ST    = 3'd2;
  localparam logic [2:0] K_OTHER = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  logic [54:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [31:0] r_inst_cnt, r_cyc_cnt;
  logic        r_overflow, r_halted;

  logic        w_stop, w_event, w_empty, w_full, w_pop, w_push;
  logic [2:0]  w_kind;
  logic [3:0]  w_reg;
  logic [15:0] w_a, w_b;
  logic [31:0] w_inst_nxt, w_cyc_nxt;

  // Instruction word is not part of the record.
  logic        w_unused;
  assign w_unused = ^inst;

`ifdef TRACE_WATCHDOG_EN
  logic r_timeout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_timeout <= 1'b0;
    else if (w_event && w_cyc_nxt == 32'd100000)
      r_timeout <= 1'b1;
  end
  assign w_stop  = r_timeout;
  assign timeout = r_timeout;
`else
  assign w_stop  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Every enabled, non-halted cycle is a retirement event.
  assign w_event = en & ~r_halted & ~w_stop;

  always_comb begin
    w_kind = K_OTHER;
    w_reg  = 4'd0;
    w_a    = 16'd0;
    w_b    = 16'd0;
    if (reg_write && mem_read) begin
      w_kind = K_LD;  w_reg = write_reg; w_a = write_data; w_b = mem_addr;
    end else if (reg_write) begin
      w_kind = K_REG; w_reg = write_reg; w_a = write_data;
    end else if (hlt) begin
      w_kind = K_HALT;
    end else if (mem_write) begin
      w_kind = K_ST;  w_a = mem_addr; w_b = mem_data;
    end
  end

  // Extra MSB on the pointers separates full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & rd_ready;
  assign w_push  = w_event & (~w_full | w_pop);

  assign w_inst_nxt = (r_inst_cnt == 32'hFFFF_FFFF) ? r_inst_cnt : r_inst_cnt + 32'd1;
  assign w_cyc_nxt  = (r_cyc_cnt  == 32'hFFFF_FFFF) ? r_cyc_cnt  : r_cyc_cnt  + 32'd1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {w_kind, pc, w_reg, w_a, w_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inst_cnt <= '0;
      r_cyc_cnt  <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_event) begin
        r_inst_cnt <= w_inst_nxt;
        r_cyc_cnt  <= w_cyc_nxt;
        if (w_full && !w_pop) r_overflow <= 1'b1;
        if (w_kind == K_HALT)  r_halted   <= 1'b1;
      end
    end
  end

  // Gate the memory output so rd_data reads zero whenever nothing is held.
  assign rd_valid    = ~w_empty;
  assign rd_data     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign inst_count  = r_inst_cnt;
  assign cycle_count = r_cyc_cnt;
  assign overflow    = r_overflow;
  assign halted      = r_halted;
endmodule
